// File: rtl/opc5ls_uart.sv
// Memory-mapped 8N1 UART for the OPC5LS CPU bus.
// Register window of four words at BASE: 0 DATA, 1 STATUS, 2 DIVISOR, 3 reserved.
// Bus reads are combinational. Writes and read side effects take place on the rising clk edge.
// The transmit path has a 4-entry FIFO feeding a shifter. The receive path has a 2-flop
// synchroniser and a single-byte holding register.
// Ports:
//   clk      system clock
//   reset_b  asynchronous active-low reset
//   address  CPU address; din write data; rnw 1 = read, 0 = write
//   dout     read data, 0 when not selected; hit  window decode
//   txd      serial output, idles high; rxd  asynchronous serial input
module opc5ls_uart #(
  parameter logic [15:0] BASE      = 16'hFF00,
  parameter logic [15:0] DIV_RESET = 16'd433
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [15:0] address,
  input  logic [15:0] din,
  input  logic        rnw,
  output logic [15:0] dout,
  output logic        hit,
  output logic        txd,
  input  logic        rxd
);

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWait} rx_state_e;

  // Bus decode
  logic wr_data, wr_status, wr_div, rd_data;

  assign hit       = (address[15:2] == BASE[15:2]);
  assign wr_data   = hit && !rnw && (address[1:0] == 2'd0);
  assign wr_status = hit && !rnw && (address[1:0] == 2'd1);
  assign wr_div    = hit && !rnw && (address[1:0] == 2'd2);
  assign rd_data   = hit &&  rnw && (address[1:0] == 2'd0);

  // Baud divisor. Small values are kept as written but run as 3.
  logic [15:0] divisor_q, div_eff, half_m1;
  logic [16:0] div_p1;

  assign div_eff = (divisor_q < 16'd3) ? 16'd3 : divisor_q;
  assign div_p1  = {1'b0, div_eff} + 17'd1;
  // (div_eff+1)/2 - 1 without an unused carry bit
  assign half_m1 = (div_eff >> 1) - {15'b0, ~div_eff[0]};

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)    divisor_q <= DIV_RESET;
    else if (wr_div) divisor_q <= din;
  end

  // TX FIFO
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       tx_full, tx_empty, tx_push, tx_pop, tx_idle;
  tx_state_e  tx_state;
  logic [16:0] tx_cnt;
  logic [7:0]  tx_shift;
  logic [2:0]  tx_bit;

  assign tx_full  = (count == 3'd4);
  assign tx_empty = (count == 3'd0);
  // A full FIFO drops the byte even when a pop frees a slot on the same edge
  assign tx_push  = wr_data && !tx_full;
  assign tx_pop   = !tx_empty &&
                    ((tx_state == TxIdle) || ((tx_state == TxStop) && (tx_cnt == 17'd0)));
  assign tx_idle  = tx_empty && (tx_state == TxIdle);

  always_ff @(posedge clk) begin
    if (tx_push) fifo_mem[wr_ptr] <= din[7:0];
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (tx_push) wr_ptr <= wr_ptr + 2'd1;
      if (tx_pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({tx_push, tx_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // TX FSM. The pop from idle loads one extra count because txd only falls on the
  // following edge. Every later bit is reloaded from the current divisor at its boundary.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      tx_state <= TxIdle;
      tx_cnt   <= 17'd0;
      tx_shift <= 8'd0;
      tx_bit   <= 3'd0;
      txd      <= 1'b1;
    end else begin
      case (tx_state)
        TxIdle: begin
          txd <= 1'b1;
          if (!tx_empty) begin
            tx_shift <= fifo_mem[rd_ptr];
            tx_cnt   <= div_p1;
            tx_state <= TxStart;
          end
        end
        TxStart: begin
          txd <= 1'b0;
          if (tx_cnt == 17'd0) begin
            txd      <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_bit   <= 3'd0;
            tx_cnt   <= {1'b0, div_eff};
            tx_state <= TxData;
          end else begin
            tx_cnt <= tx_cnt - 17'd1;
          end
        end
        TxData: begin
          if (tx_cnt == 17'd0) begin
            tx_cnt <= {1'b0, div_eff};
            if (tx_bit == 3'd7) begin
              txd      <= 1'b1;
              tx_state <= TxStop;
            end else begin
              txd      <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - 17'd1;
          end
        end
        TxStop: begin
          if (tx_cnt == 17'd0) begin
            if (!tx_empty) begin
              // Back-to-back frame: the start bit begins on this boundary
              tx_shift <= fifo_mem[rd_ptr];
              txd      <= 1'b0;
              tx_cnt   <= {1'b0, div_eff};
              tx_state <= TxStart;
            end else begin
              tx_state <= TxIdle;
            end
          end else begin
            tx_cnt <= tx_cnt - 17'd1;
          end
        end
        default: tx_state <= TxIdle;
      endcase
    end
  end

  // RX synchroniser
  logic [1:0] sync_q;
  logic       rxs;

  assign rxs = sync_q[1];

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], rxd};
  end

  // RX FSM and holding register
  rx_state_e   rx_state;
  logic [15:0] rx_cnt;
  logic [7:0]  rx_shift, rx_byte;
  logic [2:0]  rx_bit;
  logic        rx_valid, overrun, ferr;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rx_state <= RxIdle;
      rx_cnt   <= 16'd0;
      rx_shift <= 8'd0;
      rx_bit   <= 3'd0;
      rx_byte  <= 8'd0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      // Bus clears first so that same-edge receive events override them
      if (rd_data)                overrun <= overrun;
      if (rd_data)                rx_valid <= 1'b0;
      if (wr_status && din[3])    overrun  <= 1'b0;
      if (wr_status && din[4])    ferr     <= 1'b0;
      case (rx_state)
        RxIdle: begin
          if (!rxs) begin
            rx_cnt   <= half_m1;
            rx_state <= RxStart;
          end
        end
        RxStart: begin
          if (rx_cnt == 16'd0) begin
            if (!rxs) begin
              rx_cnt   <= div_eff;
              rx_bit   <= 3'd0;
              rx_state <= RxData;
            end else begin
              rx_state <= RxIdle;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        RxData: begin
          if (rx_cnt == 16'd0) begin
            rx_shift <= {rxs, rx_shift[7:1]};
            rx_cnt   <= div_eff;
            if (rx_bit == 3'd7) rx_state <= RxStop;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        RxStop: begin
          if (rx_cnt == 16'd0) begin
            if (rxs) begin
              rx_byte  <= rx_shift;
              rx_valid <= 1'b1;
              // A byte consumed on this same edge is not an overrun
              if (rx_valid && !rd_data) overrun <= 1'b1;
              rx_state <= RxIdle;
            end else begin
              ferr     <= 1'b1;
              rx_state <= RxWait;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        RxWait: begin
          if (rxs) rx_state <= RxIdle;
        end
        default: rx_state <= RxIdle;
      endcase
    end
  end

  // Read mux
  always_comb begin
    dout = 16'd0;
    if (hit) begin
      case (address[1:0])
        2'd0:    dout = {8'd0, rx_byte};
        2'd1:    dout = {11'd0, ferr, overrun, rx_valid, tx_idle, tx_full};
        2'd2:    dout = divisor_q;
        default: dout = 16'd0;
      endcase
    end
  end

endmodule
